cdb_scheduler: RTL and testbench

Sequences result writeback from several functional units (ALU, branch ALU, load unit) onto the single common data bus. Each unit deposits a finished result into its own one-entry holding register. A round-robin arbiter picks one held result per cycle and drives it onto a registered CDB output. The block replaces ad-hoc per-unit bus requests with backpressure: a unit's `available` flag tells it whether it may hand over a new result.

---
 rtl/cdb_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 54 +++++
 rtl/cdb_scheduler.sv | 122 ++++++++++++
 tb/tb_cdb_scheduler.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_pkg.sv
// cdb_pkg: shared constants and types for the CDB writeback scheduler.
//   CDB_*      default widths (MSB indices) and unit count
//   *_SRC      unit index of each functional unit on the request vector
//   cdb_entry_t  one holding-register / bus entry
//   rr_next    round-robin successor of a granted index
package cdb_pkg;

  localparam int unsigned CDB_WIDTH = 31;
  localparam int unsigned CDB_ROB   = 2;
  localparam int unsigned CDB_NREQ  = 3;
  localparam int unsigned CDB_SRC   = 1;

  localparam int unsigned ALU_SRC    = 0;
  localparam int unsigned BRANCH_SRC = 1;
  localparam int unsigned LOAD_SRC   = 2;

  typedef struct packed {
    logic                 valid;
    logic [CDB_ROB:0]     rob;
    logic [CDB_WIDTH:0]   data;
  } cdb_entry_t;

  function automatic int unsigned rr_next(input int unsigned g, input int unsigned n);
    return (g == n - 1) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter with a registered search pointer.
//   clk         clock, rising edge
//   globalReset synchronous reset, active-low (pointer to 0)
//   clear       flush; pointer is frozen during the flush cycle
//   reqVec      request vector, one bit per unit
//   grant       one-hot grant (zero when nothing requests)
//   ptr         current search start index
module rr_arbiter import cdb_pkg::*; #(
  parameter int unsigned NREQ = CDB_NREQ,
  parameter int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            globalReset,
  input  logic            clear,
  input  logic [NREQ-1:0] reqVec,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   ptr
);

  logic [PW-1:0] ptr_d, ptr_q;
  logic          found;

  // Two passes: indices ptr..NREQ-1 first, then 0..ptr-1 (wrap).
  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && reqVec[i] && (i >= 32'(ptr_q))) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        ptr_d    = PW'(rr_next(i, NREQ));
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && reqVec[i] && (i < 32'(ptr_q))) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        ptr_d    = PW'(rr_next(i, NREQ));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!globalReset) begin
      ptr_q <= '0;
    end else if (!clear) begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/cdb_scheduler.sv
// cdb_scheduler: per-unit one-entry holding registers feeding a round-robin
// arbitrated, registered common data bus.
//   clk          clock, rising edge
//   globalReset  synchronous reset, active-low (highest priority)
//   clear        pipeline flush: drops held entries, pending reqs and bus valid
//   req          unit i hands over a result this cycle
//   reqRob       packed ROB tags, unit i at [i*(ROB+1) +: ROB+1]
//   reqData      packed results, unit i at [i*(WIDTH+1) +: WIDTH+1]
//   available    unit i may assert req (empty, or being drained this cycle)
//   cdbValid     bus carries a valid result
//   cdbRob/cdbData/cdbSrc  registered bus payload; held while cdbValid is 0
module cdb_scheduler import cdb_pkg::*; #(
  parameter int unsigned WIDTH = CDB_WIDTH,
  parameter int unsigned ROB   = CDB_ROB,
  parameter int unsigned NREQ  = CDB_NREQ,
  parameter int unsigned SRC   = CDB_SRC
) (
  input  logic                      clk,
  input  logic                      globalReset,
  input  logic                      clear,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*(ROB+1)-1:0]   reqRob,
  input  logic [NREQ*(WIDTH+1)-1:0] reqData,
  output logic [NREQ-1:0]           available,
  output logic                      cdbValid,
  output logic [ROB:0]              cdbRob,
  output logic [WIDTH:0]            cdbData,
  output logic [SRC:0]              cdbSrc
);

  logic [NREQ-1:0] hold_valid;
  logic [ROB:0]    hold_rob  [NREQ];
  logic [WIDTH:0]  hold_data [NREQ];

  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] load;
  logic [SRC:0]    arb_ptr;

  logic [ROB:0]    gnt_rob;
  logic [WIDTH:0]  gnt_data;
  logic [SRC:0]    gnt_src;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (SRC + 1)
  ) u_arb (
    .clk         (clk),
    .globalReset (globalReset),
    .clear       (clear),
    .reqVec      (hold_valid),
    .grant       (grant),
    .ptr         (arb_ptr)
  );

  // A slot being granted this cycle frees up in time to take a new result.
  assign available = ~hold_valid | grant;
  assign load      = req & available;

  always_comb begin
    gnt_rob  = '0;
    gnt_data = '0;
    gnt_src  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        gnt_rob  = hold_rob[i];
        gnt_data = hold_data[i];
        gnt_src  = (SRC + 1)'(i);
      end
    end
  end

  // Holding registers: reload beats drain, so a granted slot that is
  // refilled in the same cycle stays valid. Flush drops everything.
  always_ff @(posedge clk) begin
    if (!globalReset) begin
      hold_valid <= '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
        hold_rob[i]  <= '0;
        hold_data[i] <= '0;
      end
    end else if (clear) begin
      hold_valid <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (load[i]) begin
          hold_valid[i] <= 1'b1;
          hold_rob[i]   <= reqRob[i*(ROB+1) +: ROB+1];
          hold_data[i]  <= reqData[i*(WIDTH+1) +: WIDTH+1];
        end else if (grant[i]) begin
          hold_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Bus register: payload only moves on a grant so consumers may keep
  // looking at the last result after cdbValid drops.
  always_ff @(posedge clk) begin
    if (!globalReset) begin
      cdbValid <= 1'b0;
      cdbRob   <= '0;
      cdbData  <= '0;
      cdbSrc   <= '0;
    end else if (clear) begin
      cdbValid <= 1'b0;
    end else begin
      cdbValid <= |grant;
      if (|grant) begin
        cdbRob  <= gnt_rob;
        cdbData <= gnt_data;
        cdbSrc  <= gnt_src;
      end
    end
  end

  ptr_in_range: assert property (@(posedge clk) disable iff (!globalReset)
    (32'(arb_ptr) < NREQ));

  grant_onehot: assert property (@(posedge clk) disable iff (!globalReset)
    $onehot0(grant));

endmodule

// File: tb/tb_cdb_scheduler.sv
// tb_cdb_scheduler: directed, table-driven bench for cdb_scheduler.
module tb_cdb_scheduler;
  import cdb_pkg::*;

  logic        clk = 1'b0;
  logic        globalReset = 1'b0;
  logic        clear = 1'b0;
  logic [2:0]  req = '0;
  logic [8:0]  reqRob = '0;
  logic [95:0] reqData = '0;
  logic [2:0]  available;
  logic        cdbValid;
  logic [2:0]  cdbRob;
  logic [31:0] cdbData;
  logic [1:0]  cdbSrc;

  int n_tests = 0;
  int n_fail  = 0;

  cdb_scheduler dut (
    .clk         (clk),
    .globalReset (globalReset),
    .clear       (clear),
    .req         (req),
    .reqRob      (reqRob),
    .reqData     (reqData),
    .available   (available),
    .cdbValid    (cdbValid),
    .cdbRob      (cdbRob),
    .cdbData     (cdbData),
    .cdbSrc      (cdbSrc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic [2:0] req;
    logic [2:0] r0, r1, r2;
    logic [2:0] avail;
    logic       valid;
    logic [2:0] rob;
    logic [1:0] src;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] mkdata(input logic [1:0] u, input logic [2:0] r);
    return {16'hC0DE, 6'b0, u, 5'b0, r};
  endfunction

  task automatic drive(input logic clr, input logic [2:0] rq,
                       input logic [2:0] r0, input logic [2:0] r1, input logic [2:0] r2);
    clear   = clr;
    req     = rq;
    reqRob  = {r2, r1, r0};
    reqData = {mkdata(2'd2, r2), mkdata(2'd1, r1), mkdata(2'd0, r0)};
  endtask

  task automatic add(input logic [2:0] rq, input logic [2:0] r0, input logic [2:0] r1,
                     input logic [2:0] r2, input logic [2:0] av, input logic v,
                     input logic [2:0] rob, input logic [1:0] src);
    vec_t t;
    t.clr = 1'b0; t.req = rq; t.r0 = r0; t.r1 = r1; t.r2 = r2;
    t.avail = av; t.valid = v; t.rob = rob; t.src = src;
    vq.push_back(t);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bus(input string name, input logic v, input logic [2:0] rob,
                         input logic [1:0] src, input logic [31:0] data);
    chk({name, ".valid"}, 32'(cdbValid), 32'(v));
    chk({name, ".rob"},   32'(cdbRob),   32'(rob));
    chk({name, ".src"},   32'(cdbSrc),   32'(src));
    chk({name, ".data"},  cdbData,       data);
  endtask

  // A unit asserting req while its slot is full and not draining.
  always @(posedge clk) begin
    if (globalReset && |(req & ~available)) begin
      n_fail++;
      $display("FAIL protocol: req=%b available=%b", req, available);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held, then released: idle state persists.
    drive(1'b0, 3'b000, 3'd0, 3'd0, 3'd0);
    repeat (5) begin
      tick();
      chk("rst.avail", 32'(available), 32'h7);
      chk("rst.valid", 32'(cdbValid), 32'h0);
    end
    chk_bus("rst", 1'b0, 3'd0, 2'd0, 32'h0);
    chk("rst.ptr", 32'(dut.u_arb.ptr), 32'h0);
    @(negedge clk);
    globalReset = 1'b1;
    repeat (3) begin
      tick();
      chk("idle.avail", 32'(available), 32'h7);
      chk("idle.valid", 32'(cdbValid), 32'h0);
    end

    // Single ALU result, two-cycle latency.
    @(negedge clk);
    req = 3'b001; reqRob = 9'd5; reqData = {64'h0, 32'hDEAD_BEEF};
    tick();
    chk("alu.t0.valid", 32'(cdbValid), 32'h0);
    @(negedge clk);
    drive(1'b0, 3'b000, 3'd0, 3'd0, 3'd0);
    tick();
    chk_bus("alu.t1", 1'b1, 3'd5, 2'(ALU_SRC), 32'hDEAD_BEEF);
    tick();
    chk_bus("alu.t2", 1'b0, 3'd5, 2'(ALU_SRC), 32'hDEAD_BEEF);
    chk("alu.ptr", 32'(dut.u_arb.ptr), 32'h1);

    // Reset mid-operation, with clear and a req also present.
    @(negedge clk);
    drive(1'b0, 3'b110, 3'd0, 3'd2, 3'd3);
    tick();
    chk("mrst.pre.valid", 32'(cdbValid), 32'h0);
    @(negedge clk);
    globalReset = 1'b0;
    drive(1'b1, 3'b001, 3'd4, 3'd0, 3'd0);
    tick();
    chk_bus("mrst", 1'b0, 3'd0, 2'd0, 32'h0);
    chk("mrst.avail", 32'(available), 32'h7);
    chk("mrst.ptr", 32'(dut.u_arb.ptr), 32'h0);
    @(negedge clk);
    globalReset = 1'b1;
    drive(1'b0, 3'b000, 3'd0, 3'd0, 3'd0);
    repeat (2) begin
      tick();
      chk("mrst.post.valid", 32'(cdbValid), 32'h0);
      chk("mrst.post.avail", 32'(available), 32'h7);
    end

    // Table: req, r0, r1, r2 | available (pre-edge), cdb valid/rob/src (post-edge)
    // All three together from ptr=0.
    add(3'b111, 3'd1, 3'd2, 3'd3, 3'b111, 1'b0, 3'd0, 2'd0);
    add(3'b000, 3'd0, 3'd0, 3'd0, 3'b001, 1'b1, 3'd1, 2'd0);
    add(3'b000, 3'd0, 3'd0, 3'd0, 3'b011, 1'b1, 3'd2, 2'd1);
    add(3'b000, 3'd0, 3'd0, 3'd0, 3'b111, 1'b1, 3'd3, 2'd2);
    // Move pointer to 1, then second round: order 1, 2, 0.
    add(3'b001, 3'd4, 3'd0, 3'd0, 3'b111, 1'b0, 3'd0, 2'd0);
    add(3'b000, 3'd0, 3'd0, 3'd0, 3'b111, 1'b1, 3'd4, 2'd0);
    add(3'b111, 3'd5, 3'd6, 3'd7, 3'b111, 1'b0, 3'd0, 2'd0);
    add(3'b000, 3'd0, 3'd0, 3'd0, 3'b010, 1'b1, 3'd6, 2'd1);
    add(3'b000, 3'd0, 3'd0, 3'd0, 3'b110, 1'b1, 3'd7, 2'd2);
    add(3'b000, 3'd0, 3'd0, 3'd0, 3'b111, 1'b1, 3'd5, 2'd0);
    // Back-to-back ALU, tags 0..7.
    add(3'b001, 3'd0, 3'd0, 3'd0, 3'b111, 1'b0, 3'd0, 2'd0);
    for (int k = 1; k < 8; k++)
      add(3'b001, 3'(k), 3'd0, 3'd0, 3'b111, 1'b1, 3'(k - 1), 2'd0);
    add(3'b000, 3'd0, 3'd0, 3'd0, 3'b111, 1'b1, 3'd7, 2'd0);
    add(3'b000, 3'd0, 3'd0, 3'd0, 3'b111, 1'b0, 3'd0, 2'd0);
    // Load unit alone to bring pointer back to 0.
    add(3'b100, 3'd0, 3'd0, 3'd2, 3'b111, 1'b0, 3'd0, 2'd0);
    add(3'b000, 3'd0, 3'd0, 3'd0, 3'b111, 1'b1, 3'd2, 2'd2);
    // Branch held while ALU keeps issuing (ALU stalls when not available).
    add(3'b011, 3'd1, 3'd3, 3'd0, 3'b111, 1'b0, 3'd0, 2'd0);
    add(3'b001, 3'd2, 3'd0, 3'd0, 3'b101, 1'b1, 3'd1, 2'd0);
    add(3'b000, 3'd0, 3'd0, 3'd0, 3'b110, 1'b1, 3'd3, 2'd1);
    add(3'b001, 3'd4, 3'd0, 3'd0, 3'b111, 1'b1, 3'd2, 2'd0);
    add(3'b000, 3'd0, 3'd0, 3'd0, 3'b111, 1'b1, 3'd4, 2'd0);
    add(3'b000, 3'd0, 3'd0, 3'd0, 3'b111, 1'b0, 3'd0, 2'd0);

    foreach (vq[k]) begin
      @(negedge clk);
      drive(vq[k].clr, vq[k].req, vq[k].r0, vq[k].r1, vq[k].r2);
      #1;
      chk($sformatf("v%0d.avail", k), 32'(available), 32'(vq[k].avail));
      tick();
      chk($sformatf("v%0d.valid", k), 32'(cdbValid), 32'(vq[k].valid));
      if (vq[k].valid) begin
        chk($sformatf("v%0d.rob", k), 32'(cdbRob), 32'(vq[k].rob));
        chk($sformatf("v%0d.src", k), 32'(cdbSrc), 32'(vq[k].src));
        chk($sformatf("v%0d.data", k), cdbData, mkdata(vq[k].src, vq[k].rob));
      end
    end
    chk("tbl.ptr", 32'(dut.u_arb.ptr), 32'h1);

    // Flush with all three held, plus a reload of the unit being granted.
    @(negedge clk);
    drive(1'b0, 3'b111, 3'd1, 3'd2, 3'd3);
    tick();
    chk("clr.load.valid", 32'(cdbValid), 32'h0);
    @(negedge clk);
    drive(1'b1, 3'b010, 3'd0, 3'd5, 3'd0);
    #1;
    chk("clr.avail.pre", 32'(available), 32'h2);
    tick();
    chk("clr.valid", 32'(cdbValid), 32'h0);
    chk("clr.avail.post", 32'(available), 32'h7);
    chk("clr.ptr", 32'(dut.u_arb.ptr), 32'h1);
    @(negedge clk);
    drive(1'b0, 3'b000, 3'd0, 3'd0, 3'd0);
    repeat (3) begin
      tick();
      chk("clr.after.valid", 32'(cdbValid), 32'h0);
    end
    // Pointer survived the flush: next round starts at unit 1.
    @(negedge clk);
    drive(1'b0, 3'b111, 3'd1, 3'd2, 3'd3);
    tick();
    @(negedge clk);
    drive(1'b0, 3'b000, 3'd0, 3'd0, 3'd0);
    #1;
    chk("clr.rr.avail", 32'(available), 32'h2);
    tick();
    chk_bus("clr.rr0", 1'b1, 3'd2, 2'd1, mkdata(2'd1, 3'd2));
    tick();
    chk_bus("clr.rr1", 1'b1, 3'd3, 2'd2, mkdata(2'd2, 3'd3));
    tick();
    chk_bus("clr.rr2", 1'b1, 3'd1, 2'd0, mkdata(2'd0, 3'd1));
    tick();
    chk("clr.rr3.valid", 32'(cdbValid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
